sigma_delta_backend: RTL and testbench
======================================

SIGMA_DELTA_BACKEND -- requirements
Module: sigma_delta_backend

Interface
REQ-001 Parameter OSR_LOG2, default 8, SHALL set the window to 2^OSR_LOG2 clk cycles; legal 4..12.
REQ-002 Parameter CW, fixed at OSR_LOG2+1, SHALL be the width of the ones-count result.
REQ-003 clk  input  1  SHALL be the single clock; all state rises on posedge clk.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 en  input  1  SHALL enable modulation and accumulation when high.
REQ-006 cmp_in  input  1  SHALL carry the asynchronous comparator output of the upstream op-amp stage.
REQ-007 fb_out  output  1  SHALL drive the 1-bit feedback DAC switch back into the op-amp integrator.
REQ-008 sample_data  output  CW  SHALL hold the ones count of the last completed window.
REQ-009 sample_valid  output  1  SHALL flag that sample_data holds an unconsumed result.
REQ-010 sample_ready  input  1  SHALL signal consumer acceptance.
REQ-011 overrun  output  1  SHALL be a sticky flag for an unconsumed result overwritten by a new one.
REQ-012 clr_overrun  input  1  SHALL clear overrun when high.

Function
REQ-013 cmp_in SHALL pass through two flops before any use; the second-stage output is cmp_s, delayed 2 cycles from cmp_in.
REQ-014 The synchronizer SHALL run regardless of en.
REQ-015 fb_out SHALL be a register loaded with cmp_s each cycle while en=1, giving 3 cycles from cmp_in to fb_out.
REQ-016 fb_out SHALL load 0 on every cycle with en=0.
REQ-017 A phase counter (OSR_LOG2 bits) SHALL increment on each cycle with en=1 and wrap from 2^OSR_LOG2-1 to 0.
REQ-018 The accumulator (CW bits) SHALL add cmp_s on each cycle with en=1.
REQ-019 On an en=1 cycle with phase=2^OSR_LOG2-1, the following SHALL happen at the next edge:
  - sample_data <= acc+cmp_s;
  - sample_valid <= 1;
  - acc <= 0.
REQ-020 The result SHALL range 0..2^OSR_LOG2 without overflow (full window of ones = 2^OSR_LOG2).
REQ-021 A cycle with en=0 SHALL clear phase and acc, aborting the partial window with no result.
REQ-022 An en=0 cycle SHALL leave sample_data, sample_valid and overrun unchanged.
REQ-023 Handshake: a transfer SHALL occur on an edge where sample_valid=1 and sample_ready=1.
REQ-024 After a transfer with no new result in that cycle, sample_valid SHALL go to 0.
REQ-025 sample_data SHALL remain stable while sample_valid=1, except when a new result loads.
REQ-026 New result with sample_valid=0: load the result and set valid; overrun unchanged.
REQ-027 New result with a transfer in the same cycle: load the result, keep valid=1, no overrun.
REQ-028 New result with sample_valid=1 and sample_ready=0:
  - load the result (overwriting the old one);
  - keep valid=1;
  - set overrun=1.
REQ-029 clr_overrun=1 SHALL clear overrun at the next edge.
REQ-030 If an overrun event and clr_overrun occur in the same cycle, set SHALL win.
REQ-031 sample_ready SHALL be ignored while sample_valid=0.

Reset
REQ-032 rst=1 SHALL immediately, without a clock edge, force all of the following to 0:
  - both synchronizer flops;
  - fb_out;
  - phase and acc;
  - sample_data, sample_valid and overrun.
REQ-033 Assertion of rst mid-window SHALL discard the partial window.
REQ-034 After rst deasserts, the first en=1 cycle SHALL be phase 0.

Verification
REQ-035 OSR_LOG2=8, cmp_in=1 and en=1 from reset release, sample_ready=1 -> window results are:
  - first window = 254 (synchronizer fill);
  - later windows = 256;
  - sample_valid pulses 1 cycle every 256 cycles.
REQ-036 cmp_in toggling every cycle, en=1, sample_ready=1 -> every result after the first window = 128; fb_out = cmp_in delayed 3 cycles.
REQ-037 sample_ready=0 across two window ends with cmp_in=1 -> all of:
  - sample_data = 256 from the second window;
  - sample_valid = 1;
  - overrun = 1.
  Then clr_overrun=1 for one cycle -> overrun=0 with sample_valid still 1.
REQ-038 en dropped for 1 cycle at phase 100, then held high with cmp_in=1 -> all of:
  - no result emitted at the original window end;
  - the next result is 256, 256 cycles after re-enable;
  - fb_out=0 on the cycle after the en=0 cycle.
REQ-039 rst pulsed mid-window between clock edges -> all outputs read 0 before the next posedge; the first window after release behaves as in REQ-035.
REQ-040 Window end coincides with sample_ready=1 and sample_valid=1 -> new data loads, sample_valid stays 1, overrun stays 0.

Source files
------------

// File: rtl/sigma_delta_backend.sv
// Purpose: first-order sigma-delta digital backend. It synchronises the comparator, drives the 1-bit feedback DAC and counts ones per window.
// Latency: cmp_in reaches fb_out after 3 cycles. A window result is registered on the edge that closes its 2^OSR_LOG2-cycle window.
// Backpressure: one output register with valid/ready. A result that arrives while the previous one is unconsumed overwrites it and sets the sticky overrun flag.
module sigma_delta_backend #(
  parameter int OSR_LOG2 = 8,
  localparam int CW      = OSR_LOG2 + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cmp_in,
  output logic          fb_out,
  output logic [CW-1:0] sample_data,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          overrun,
  input  logic          clr_overrun
);

  localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;

  // Two-flop synchronizer for the asynchronous comparator output.
  logic sync1_q, sync2_q;
  logic cmp_s;

  // Modulator feedback register
  logic fb_q, fb_d;

  // Window state
  logic [OSR_LOG2-1:0] phase_q, phase_d;
  logic [CW-1:0]       acc_q, acc_d;
  logic                win_end;
  logic [CW-1:0]       result;

  // Output register state
  logic [CW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          xfer;

  assign cmp_s = sync2_q;

  // The synchronizer is free-running and ignores en, so the feedback path never sees an unsynchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= cmp_in;
      sync2_q <= sync1_q;
    end
  end

  // The feedback follows the synchronised comparator while enabled. It is forced to 0 when disabled so the DAC stops injecting charge.
  always_comb begin
    fb_d = en & cmp_s;
  end

  // A window closes on the enabled cycle that sits at the last phase. The closing sample is included in the result.
  // The accumulator is CW bits wide, so a full window of ones (2^OSR_LOG2) fits without overflow.
  assign win_end = en && (phase_q == PHASE_LAST);
  assign result  = acc_q + CW'(cmp_s);

  // Phase and accumulator next-state. Dropping en aborts the partial window, so the next enabled cycle starts again at phase 0.
  always_comb begin
    phase_d = phase_q;
    acc_d   = acc_q;
    if (!en) begin
      phase_d = '0;
      acc_d   = '0;
    end else begin
      phase_d = phase_q + 1'b1;
      acc_d   = win_end ? '0 : result;
    end
  end

  // Output register next-state.
  // The consumer side is independent of en: en gates only modulation and accumulation, and a disabled modulator cannot produce a result.
  // ready is only meaningful while valid is high.
  // A new result always loads, even over an unconsumed one. Losing the old result is recorded in overrun, and setting overrun takes priority over clearing it.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    xfer    = valid_q & sample_ready;

    if (win_end) begin
      data_d  = result;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    if (win_end && valid_q && !sample_ready) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  // Register all datapath and handshake state. Reset clears everything immediately, which discards any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_q    <= 1'b0;
      phase_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      fb_q    <= fb_d;
      phase_q <= phase_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign fb_out       = fb_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_sigma_delta_backend.sv
// Purpose: scoreboard bench for sigma_delta_backend with OSR_LOG2=8 (256-cycle windows).
// Latency: expected results are queued by the stimulus and popped by a negedge monitor on every accepted transfer.
// Backpressure: sample_ready is driven per scenario to exercise transfer, hold, overrun and coincident load.
module tb_sigma_delta_backend;

  localparam int CW = 9;

  logic          clk;
  logic          rst;
  logic          en;
  logic          cmp_in;
  logic          fb_out;
  logic [CW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          clr_overrun;

  int total;
  int bad;
  int cyc;
  int rel;
  int pop_cnt;
  int sb[$];
  int pop_cycles[$];

  sigma_delta_backend dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cmp_in       (cmp_in),
    .fb_out       (fb_out),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clr_overrun  (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle index: after edge k (and until the next edge) cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted transfer must match the oldest expected result.
  task automatic monitor();
    int exp;
    forever begin
      @(negedge clk);
      if (!rst && sample_valid && sample_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got result %0d with no expected entry (cycle %0d)", sample_data, cyc);
        end else begin
          exp = sb.pop_front();
          chk("sb_data", int'(sample_data), exp);
        end
        pop_cnt++;
        pop_cycles.push_back(cyc);
      end
    end
  endtask

  // Advance to just after edge 'target'. Inputs driven afterwards apply at edge target+1.
  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k;
    k = 0;
    while (pop_cnt < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("pop_timeout", pop_cnt, n);
  endtask

  // Reset, then release between clock edges with the scenario's inputs already applied.
  task automatic do_reset(input logic e, input logic c, input logic r);
    rst          = 1'b1;
    en           = 1'b0;
    cmp_in       = 1'b0;
    sample_ready = 1'b0;
    clr_overrun  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    en           = e;
    cmp_in       = c;
    sample_ready = r;
    rst          = 1'b0;
    rel          = cyc;
  endtask

  initial begin
    int base;
    int drv[$];
    int expv;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    pop_cnt = 0;
    rst          = 1'b1;
    en           = 1'b0;
    cmp_in       = 1'b0;
    sample_ready = 1'b0;
    clr_overrun  = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fb", fb_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", int'(sample_data), 0);
    chk("rst_ovr", overrun, 0);

    // Constant ones: 254 (synchronizer fill), then 256, one-cycle valid pulses 256 apart
    sb.push_back(254);
    sb.push_back(256);
    sb.push_back(256);
    base = pop_cnt;
    do_reset(1'b1, 1'b1, 1'b1);
    wait_pops(base + 3, 1000);
    if (pop_cycles.size() >= base + 3) begin
      chk("ones_first_lat", pop_cycles[base] - rel, 256);
      chk("ones_gap1", pop_cycles[base + 1] - pop_cycles[base], 256);
      chk("ones_gap2", pop_cycles[base + 2] - pop_cycles[base + 1], 256);
    end
    @(negedge clk);
    chk("ones_valid_pulse", sample_valid, 0);

    // Toggling comparator: 127 for the first window, then 128; fb_out is cmp_in delayed 3 cycles
    sb.push_back(127);
    sb.push_back(128);
    sb.push_back(128);
    base = pop_cnt;
    drv.delete();
    do_reset(1'b1, 1'b1, 1'b1);
    drv.push_back(1);
    for (int j = 1; j <= 770; j++) begin
      wait_cyc(rel + j);
      cmp_in = ~cmp_in;
      drv.push_back(int'(cmp_in));
      @(negedge clk);
      if (j <= 40) begin
        expv = (j >= 3) ? drv[j - 3] : 0;
        chk("tog_fb", fb_out, expv);
      end
    end
    wait_pops(base + 3, 100);

    // Backpressure: hold, overrun, clear, set-wins, drain, coincident load
    do_reset(1'b1, 1'b1, 1'b0);
    wait_cyc(rel + 256);
    @(negedge clk);
    chk("bp_w1_valid", sample_valid, 1);
    chk("bp_w1_data", int'(sample_data), 254);
    chk("bp_w1_ovr", overrun, 0);
    wait_cyc(rel + 512);
    clr_overrun = 1'b1;
    @(negedge clk);
    chk("bp_w2_data", int'(sample_data), 256);
    chk("bp_w2_valid", sample_valid, 1);
    chk("bp_w2_ovr", overrun, 1);
    wait_cyc(rel + 513);
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("bp_clr_ovr", overrun, 0);
    chk("bp_clr_valid", sample_valid, 1);
    wait_cyc(rel + 767);
    clr_overrun = 1'b1;
    wait_cyc(rel + 768);
    @(negedge clk);
    chk("bp_setwins_ovr", overrun, 1);
    chk("bp_w3_data", int'(sample_data), 256);
    wait_cyc(rel + 769);
    clr_overrun  = 1'b0;
    sb.push_back(256);
    sample_ready = 1'b1;
    @(negedge clk);
    chk("bp_clr2_ovr", overrun, 0);
    chk("bp_clr2_valid", sample_valid, 1);
    wait_cyc(rel + 770);
    sample_ready = 1'b0;
    @(negedge clk);
    chk("bp_drain_valid", sample_valid, 0);
    wait_cyc(rel + 1024);
    @(negedge clk);
    chk("bp_w4_valid", sample_valid, 1);
    chk("bp_w4_ovr", overrun, 0);
    wait_cyc(rel + 1279);
    sample_ready = 1'b1;
    sb.push_back(256);
    sb.push_back(256);
    wait_cyc(rel + 1280);
    @(negedge clk);
    chk("coinc_valid", sample_valid, 1);
    chk("coinc_ovr", overrun, 0);
    chk("coinc_data", int'(sample_data), 256);
    wait_cyc(rel + 1281);
    @(negedge clk);
    chk("coinc_after_valid", sample_valid, 0);

    // en dropped for one cycle at phase 100: window restarts, no result at the old boundary
    sb.push_back(256);
    base = pop_cnt;
    do_reset(1'b1, 1'b1, 1'b1);
    wait_cyc(rel + 100);
    en = 1'b0;
    wait_cyc(rel + 101);
    en = 1'b1;
    @(negedge clk);
    chk("en_fb_low", fb_out, 0);
    wait_cyc(rel + 102);
    @(negedge clk);
    chk("en_fb_back", fb_out, 1);
    wait_cyc(rel + 256);
    @(negedge clk);
    chk("en_no_old_result", sample_valid, 0);
    wait_pops(base + 1, 300);
    if (pop_cycles.size() >= base + 1)
      chk("en_result_lat", pop_cycles[base] - rel, 357);

    // Asynchronous reset mid-window with a pending result
    do_reset(1'b1, 1'b1, 1'b0);
    wait_cyc(rel + 300);
    @(negedge clk);
    chk("arst_pre_valid", sample_valid, 1);
    chk("arst_pre_fb", fb_out, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_fb", fb_out, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_data", int'(sample_data), 0);
    chk("arst_ovr", overrun, 0);
    sb.push_back(254);
    sb.push_back(256);
    base = pop_cnt;
    do_reset(1'b1, 1'b1, 1'b1);
    wait_pops(base + 2, 700);
    if (pop_cycles.size() >= base + 2)
      chk("arst_first_lat", pop_cycles[base] - rel, 256);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
